// File: rtl/fir_seq_mac.sv
// Time-multiplexed FIR filter: one signed multiply-accumulate per cycle over a
// circular delay line, with run-time programmable taps, rounding and saturation.
module fir_seq_mac #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 19,
  parameter int ACC_W     = 40,
  parameter int OUT_SHIFT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_sat,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  output logic                     coef_err,
  output logic                     busy
);

  localparam int AW = $clog2(TAPS);
  localparam int PW = DATA_W + COEF_W;

  // Half an output LSB; (1 << S) >> 1 also gives 0 when no shift is applied.
  localparam logic signed [ACC_W:0] RND     = ((ACC_W+1)'(1) << OUT_SHIFT) >> 1;
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                         state_q;
  logic [TAPS-1:0][DATA_W-1:0]    x_q;
  logic [TAPS-1:0][COEF_W-1:0]    coef_q;
  logic [AW-1:0]                  wp_q;
  logic [AW-1:0]                  rd_q;
  logic [AW-1:0]                  k_q;
  logic signed [ACC_W-1:0]        acc_q;
  logic                           in_ready_q;
  logic                           busy_q;
  logic                           out_valid_q;
  logic [DATA_W-1:0]              out_data_q;
  logic                           out_sat_q;
  logic                           coef_err_q;

  logic signed [PW-1:0]           prod;
  logic signed [ACC_W-1:0]        acc_d;
  logic signed [ACC_W:0]          rnd_sum;
  logic signed [ACC_W:0]          shifted;
  logic [DATA_W-1:0]              out_data_d;
  logic                           out_sat_d;
  logic [AW-1:0]                  wp_d;
  logic [AW-1:0]                  rd_d;
  logic                           addr_ok;
  logic                           last_tap;

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign coef_err  = coef_err_q;

  assign addr_ok  = ({1'b0, coef_addr} < (AW+1)'(TAPS));
  assign last_tap = (k_q == AW'(TAPS-1));

  // The read pointer walks backwards from the newest sample, so tap k meets x[n-k].
  assign wp_d = (wp_q == AW'(TAPS-1)) ? '0 : wp_q + AW'(1);
  assign rd_d = (rd_q == '0) ? AW'(TAPS-1) : rd_q - AW'(1);

  // NOTE: every signal written in always_comb gets a value up front, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    out_data_d = '0;
    out_sat_d  = 1'b0;
    prod       = PW'($signed(x_q[rd_q])) * PW'($signed(coef_q[k_q]));
    acc_d      = acc_q + ACC_W'(prod);
    rnd_sum    = (ACC_W+1)'(acc_q) + RND;
    shifted    = rnd_sum >>> OUT_SHIFT;
    if (shifted > SAT_MAX) begin
      out_data_d = SAT_MAX[DATA_W-1:0];
      out_sat_d  = 1'b1;
    end else if (shifted < SAT_MIN) begin
      out_data_d = SAT_MIN[DATA_W-1:0];
      out_sat_d  = 1'b1;
    end else begin
      out_data_d = shifted[DATA_W-1:0];
    end
  end

  // NOTE: the delay line and coefficient bank are flops rather than a RAM
  // macro because they must read as zero straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coef_q     <= '0;
      coef_err_q <= 1'b0;
    end else begin
      coef_err_q <= 1'b0;
      if (coef_we) begin
        if (state_q == IDLE && addr_ok) begin
          coef_q[coef_addr] <= coef_wdata;
        end else begin
          coef_err_q <= 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      x_q         <= '0;
      wp_q        <= '0;
      rd_q        <= '0;
      k_q         <= '0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q[wp_q]  <= in_data;
            acc_q      <= '0;
            k_q        <= '0;
            rd_q       <= wp_q;
            state_q    <= MAC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          rd_q  <= rd_d;
          if (last_tap) begin
            state_q <= DONE;
          end else begin
            k_q <= k_q + AW'(1);
          end
        end
        DONE: begin
          out_data_q  <= out_data_d;
          out_sat_q   <= out_sat_d;
          out_valid_q <= 1'b1;
          wp_q        <= wp_d;
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_seq_mac.sv
// Randomised scoreboard bench for fir_seq_mac against a direct-form FIR model
// built from a sample-history queue and plain integer arithmetic.
module tb_fir_seq_mac;

  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int TAPS      = 19;
  localparam int ACC_W     = 40;
  localparam int OUT_SHIFT = 15;
  localparam int AW        = $clog2(TAPS);

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_sat;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_wdata;
  logic              coef_err;
  logic              busy;

  fir_seq_mac #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_err(coef_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint d;
    bit     sat;
  } exp_t;

  exp_t   exp_q[$];
  int     acc_t_q[$];
  int     hist[$];
  int     coef_m[TAPS];
  int     n_vec, n_chk, n_err, n_out, n_coef_err, exp_coef_err;
  int     cyc, last_acc, low_run;
  bit     rdy_prev, vrun;

  task automatic check(input string name, input longint got, input longint want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < TAPS; k++) coef_m[k] = 0;
    hist.delete();
    for (int k = 0; k < TAPS; k++) hist.push_back(0);
  endfunction

  // y[n] = sum coef[k]*x[n-k], then round half up, shift and clamp.
  function automatic exp_t model_step(input int x);
    exp_t   e;
    longint acc, r;
    hist.push_front(x);
    void'(hist.pop_back());
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += longint'(coef_m[k]) * longint'(hist[k]);
    r = (acc + (longint'(1) << (OUT_SHIFT - 1))) >>> OUT_SHIFT;
    e.sat = 1'b0;
    if (r > 32767) begin
      r = 32767;
      e.sat = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      e.sat = 1'b1;
    end
    e.d = r;
    return e;
  endfunction

  // Monitor: samples 1 ns after each rising edge and checks handshake timing
  // and every presented result against the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (!reset) begin
      if (in_valid && rdy_prev) begin
        if (vrun && last_acc >= 0) check("accept_spacing", cyc - last_acc, TAPS + 2);
        last_acc = cyc;
        vrun = 1'b1;
        acc_t_q.push_back(cyc);
      end else if (!in_valid) begin
        vrun = 1'b0;
      end
      if (!in_ready) begin
        low_run++;
      end else begin
        if (low_run > 0) check("ready_low_cycles", low_run, TAPS + 1);
        low_run = 0;
      end
      if (out_valid) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", longint'($signed(out_data)), e.d);
          check("out_sat", longint'(out_sat), longint'(e.sat));
        end
        if (acc_t_q.size() > 0) check("latency", cyc - acc_t_q.pop_front(), TAPS + 1);
      end
      if (coef_err) n_coef_err++;
    end
    rdy_prev = in_ready;
  end

  task automatic write_coef(input int addr, input int val, input bit applied);
    coef_we    = 1'b1;
    coef_addr  = AW'(addr);
    coef_wdata = COEF_W'(val);
    if (applied) coef_m[addr] = int'($signed(COEF_W'(val)));
    else exp_coef_err++;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // Presents a sample from a falling edge; returns on the falling edge after
  // the accept edge. With hold set, in_valid stays high for the next call.
  task automatic send(input int x, input bit hold);
    int guard;
    in_valid = 1'b1;
    in_data  = DATA_W'(x);
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model_step(x));
    n_vec++;
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
      acc_t_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, longint'(in_ready), 1);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_out_valid"}, longint'(out_valid), 0);
    check({tag, "_out_data"}, longint'($signed(out_data)), 0);
    check({tag, "_out_sat"}, longint'(out_sat), 0);
    check({tag, "_coef_err"}, longint'(coef_err), 0);
  endtask

  initial begin
    int n0, e0, v;
    bit hold;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_wdata = '0;
    last_acc = -1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clk);

    // Impulse response with coef[k] = 100*(k+1).
    for (int k = 0; k < TAPS; k++) write_coef(k, 100 * (k + 1), 1'b1);
    send(-32768, 1'b0);
    for (int i = 0; i < TAPS; i++) send(0, 1'b0);
    wait_idle();

    // Rounding: a single half-scale tap.
    for (int k = 0; k < TAPS; k++) write_coef(k, (k == 0) ? 16384 : 0, 1'b1);
    send(3, 1'b0);
    send(-3, 1'b0);
    send(1000, 1'b0);
    wait_idle();

    // Saturation: (-1.0) * (-1.0) overflows the output range.
    write_coef(0, -32768, 1'b1);
    send(-32768, 1'b0);
    send(0, 1'b0);
    wait_idle();

    // Continuous in_valid: back-to-back accepts with random taps and data.
    for (int k = 0; k < TAPS; k++) write_coef(k, int'($urandom_range(65535)), 1'b1);
    for (int i = 0; i < 8; i++) send(int'($signed(16'($urandom))), 1'b1);
    in_valid = 1'b0;
    wait_idle();

    // Coefficient write during MAC is dropped and flagged.
    e0 = n_coef_err;
    send(1234, 1'b0);
    repeat (3) @(negedge clk);
    write_coef(0, 777, 1'b0);
    wait_idle();
    check("coef_err_busy", n_coef_err - e0, 1);
    write_coef(0, 777, 1'b1);
    send(1234, 1'b0);
    wait_idle();
    check("coef_err_idle", n_coef_err - e0, 1);

    // Write coinciding with the accept edge is used by that sample.
    coef_we    = 1'b1;
    coef_addr  = AW'(1);
    coef_wdata = COEF_W'(-5000);
    coef_m[1]  = -5000;
    send(20000, 1'b0);
    coef_we = 1'b0;
    wait_idle();

    // Randomised traffic: random taps, extreme and random samples, gaps and holds.
    for (int g = 0; g < 15; g++) begin
      for (int j = 0; j < 3; j++)
        write_coef(int'($urandom_range(TAPS - 1)), int'($urandom_range(65535)), 1'b1);
      for (int i = 0; i < 10; i++) begin
        hold = 1'($urandom_range(1));
        case ($urandom_range(3))
          0:       v = 32767;
          1:       v = -32768;
          default: v = int'($signed(16'($urandom)));
        endcase
        send(v, hold);
        if (!hold) repeat ($urandom_range(3)) @(negedge clk);
      end
      in_valid = 1'b0;
      wait_idle();
    end

    // Reset at tap index 7 discards the computation and clears the taps.
    send(500, 1'b0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    acc_t_q.delete();
    model_reset();
    low_run = 0;
    vrun = 1'b0;
    last_acc = -1;
    n0 = n_out;
    @(negedge clk);
    check_reset_outputs("midmac_rst");
    reset = 1'b0;
    repeat (25) @(negedge clk);
    check("no_out_after_reset", n_out - n0, 0);
    send(-32768, 1'b0);
    for (int i = 0; i < TAPS; i++) send(0, 1'b0);
    wait_idle();

    check("coef_err_total", n_coef_err, exp_coef_err);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
